// File: rtl/gsram_port_arbiter_if.sv
// gsram_port_arbiter_if: requester-side bus of the SRAM port arbiter.
// master = requester pool, slave = arbiter.
interface gsram_port_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [43:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        ready;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, ready);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, ready);
endinterface

// File: rtl/gsram_port_arbiter.sv
// gsram_port_arbiter: round-robin sharing of SRAM port 0 among 4 requesters.
// Define SRAM_CLEAR_EN to zero the whole SRAM through port 1 after reset.
module gsram_port_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    gsram_port_arbiter_if.slave        bus,
    output logic [10:0]                a0,
    output logic [7:0]                 d0,
    output logic                       we0,
    output logic                       ce0,
    input  logic [7:0]                 q0,
    output logic [10:0]                a1,
    output logic [7:0]                 d1,
    output logic                       we1,
    output logic                       ce1
);
    logic [1:0] ptr, sel;
    logic       hit, go, ready;
    logic [3:0] rvalid;

    // Descending scan so the requester closest to ptr is assigned last and wins.
    always_comb begin
        hit = 1'b0;
        sel = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[ptr + 2'(k)]) begin
                hit = 1'b1;
                sel = ptr + 2'(k);
            end
    end

    assign go         = hit & ready;
    assign bus.gnt    = go ? 4'b0001 << sel : 4'b0000;
    assign ce0        = go;
    assign we0        = go & bus.we[sel];
    assign a0         = go ? bus.addr[11*sel +: 11] : 11'd0;
    assign d0         = go ? bus.wdata[8*sel +: 8] : 8'd0;
    assign bus.ready  = ready;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = |rvalid ? q0 : 8'd0;

    always_ff @(posedge clk)
        if (rst) begin
            ptr    <= 2'd0;
            rvalid <= 4'b0000;
        end else begin
            if (go) ptr <= sel + 2'd1;
            rvalid <= (go && !bus.we[sel]) ? bus.gnt : 4'b0000;
        end

`ifdef SRAM_CLEAR_EN
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]  state;
    logic [10:0] cnt;

    always_ff @(posedge clk)
        if (rst) begin
            state <= INIT;
            cnt   <= 11'd0;
        end else if (state == INIT) begin
            cnt <= cnt + 11'd1;
            if (&cnt) state <= RUN;
        end

    assign ready = (state == RUN) & ~rst;
    assign ce1   = state == INIT;
    assign we1   = state == INIT;
    assign a1    = state == INIT ? cnt : 11'd0;
    assign d1    = 8'd0;
`else
    assign ready = ~rst;
    assign ce1   = 1'b0;
    assign we1   = 1'b0;
    assign a1    = 11'd0;
    assign d1    = 8'd0;
`endif
endmodule

// File: doc/gsram_port_arbiter.md
GSRAM_PORT_ARBITER -- requirements
Module: gsram_port_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing SRAM port 0; fixed at 4 for this release.
REQ-002 CLK  input  1  single clock; every register updates on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester access request; held high until granted.
REQ-005 we  input  4  per-requester write qualifier (1 = write, 0 = read), sampled with req.
REQ-006 addr  input  44  packed requester addresses; requester i uses bits [11i+10:11i].
REQ-007 wdata  input  32  packed write data; requester i uses bits [8i+7:8i].
REQ-008 gnt  output  4  one-hot acceptance pulse; combinational in the accepting cycle.
REQ-009 rvalid  output  4  one-hot read-return strobe, registered.
REQ-010 rdata  output  8  read data, valid while any rvalid bit is high.
REQ-011 ready  output  1  high when the arbiter accepts requests.
REQ-012 A0/D0/WE0/CE0  output  11/8/1/1  SRAM port-0 address, data, write enable, chip enable.
REQ-013 Q0  input  8  SRAM port-0 read data, valid one cycle after a CE0 read.
REQ-014 A1/D1/WE1/CE1  output  11/8/1/1  SRAM port-1 drive, used only by the clear sequencer.

Function
REQ-015 States: INIT (clear in progress) and RUN; no other states.
REQ-016 In RUN, at most one gnt bit SHALL be high per cycle, only for a requester with req high.
REQ-017 Arbitration SHALL be round-robin: search starts at ptr, then ptr+1 … ptr+3 mod 4; the first requester found with req high wins.
REQ-018 After a grant to requester i, ptr SHALL become (i+1) mod 4; with no grant, ptr SHALL hold.
REQ-019 In the grant cycle, drive CE0=1, A0=addr[i], D0=wdata[i], WE0=we[i]; in all other cycles, drive CE0=0 and WE0=0.
REQ-020 For a granted read, rvalid[i] SHALL pulse exactly one cycle later with rdata=Q0; writes SHALL produce no rvalid.
REQ-021 Back-to-back grants SHALL be sustained, at one access per cycle with no bubble.
REQ-022 gnt SHALL be all-zero whenever ready=0.
REQ-023 In RUN, port 1 SHALL be idle: CE1=0, WE1=0, A1=0, D1=0.

Reset
REQ-024 On RST: ptr=0, rvalid=0, gnt=0, CE0=WE0=0, A0=0, D0=0.
REQ-025 RST asserted mid-operation SHALL discard any pending read return; no rvalid is issued in the cycle after RST.
REQ-026 After RST, the state SHALL be INIT if SRAM_CLEAR_EN is defined; otherwise it SHALL be RUN with ready=1.

Configuration
REQ-027 Macro SRAM_CLEAR_EN defined: INIT uses an 11-bit counter from 0 and drives CE1=WE1=1, A1=counter, D1=0 each cycle.
REQ-028 With SRAM_CLEAR_EN defined, the INIT transition to RUN occurs after address 2047 is written (2048 cycles); ready is 0 throughout INIT and rises in the following cycle.
REQ-029 With SRAM_CLEAR_EN defined, RST during INIT SHALL restart the counter at 0.
REQ-030 Macro SRAM_CLEAR_EN undefined: no counter and no INIT state; port 1 is tied idle permanently.

Verification
REQ-031 Clear: with SRAM_CLEAR_EN defined, release RST -> ready=0 for 2048 cycles; then reading any address (e.g. 0x7FF) returns 0x00.
REQ-032 Round-robin: req=4'b1111 held continuously from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-033 Write/read: requester 2 writes 0xA5 to 0x123, then requester 0 reads 0x123 -> rvalid=4'b0001 one cycle after gnt, rdata=0xA5.
REQ-034 Fairness: req[0] held continuously, req[3] raised once -> req[3] granted within 4 cycles.
REQ-035 Reset mid-read: assert RST in the cycle gnt is issued for a read -> rvalid stays 0 on the next cycle.
